// File: rtl/nec_ir_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_pkg
// Description : Shared types and timing windows for the NEC IR frame decoder.
//               All durations are expressed in measurement ticks (10 us each
//               at the nominal tick rate).
// Revision    : 1.0 - initial release
// ============================================================================
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } nec_state_t;

    localparam int DUR_W = 11;
    typedef logic [DUR_W-1:0] dur_t;

    // Duration counter ceiling; reaching it means the line has gone quiet.
    localparam dur_t DUR_MAX = '1;

    localparam dur_t LEAD_MARK_MIN  = 11'd800;
    localparam dur_t LEAD_MARK_MAX  = 11'd1000;
    localparam dur_t LEAD_DATA_MIN  = 11'd400;
    localparam dur_t LEAD_DATA_MAX  = 11'd500;
    localparam dur_t LEAD_REP_MIN   = 11'd200;
    localparam dur_t LEAD_REP_MAX   = 11'd250;
    localparam dur_t BIT_MARK_MIN   = 11'd40;
    localparam dur_t BIT_MARK_MAX   = 11'd70;
    localparam dur_t SPACE0_MIN     = 11'd40;
    localparam dur_t SPACE0_MAX     = 11'd70;
    localparam dur_t SPACE1_MIN     = 11'd140;
    localparam dur_t SPACE1_MAX     = 11'd190;
    localparam dur_t STOP_MARK_MIN  = 11'd40;
    localparam dur_t STOP_MARK_MAX  = 11'd70;

    localparam int NEC_BITS = 32;

    // Inclusive window test on a measured duration.
    function automatic logic in_window(input dur_t d, input dur_t lo, input dur_t hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nec_ir_decoder_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : ClockDivider
// Description : Free-running divider producing a one-clock tick strobe every
//               VALUE clocks. VALUE = 1 yields a tick on every clock.
// Ports       : clk_i  - clock
//               rst_ni - asynchronous active-low reset
//               tick_o - one-clock strobe every VALUE clocks
// Revision    : 1.0 - initial release
// ============================================================================
module ClockDivider #(
    parameter int unsigned VALUE = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned     c_CW   = (VALUE > 1) ? $clog2(VALUE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(VALUE - 1);

    logic [c_CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_q == c_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_decoder
// Description : Decodes NEC infrared frames from a filtered, active-high mark
//               line. Each accepted 32-bit code is presented on dataOUT with a
//               one-clock strobe; optional repeat frames re-strobe the last
//               accepted code.
// Ports       : clkIN           - system clock
//               nResetIN        - asynchronous active-low reset
//               rxIN            - IR line, 1 = mark, already synchronised
//               dataReceivedOUT - one-clock strobe, dataOUT holds a new code
//               dataOUT         - last accepted code, first bit in [31]
// Revision    : 1.0 - initial release
// ============================================================================
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED   = 50_000_000,
    parameter int unsigned TICK_HZ       = 100_000,
    parameter bit          CHECK_INVERSE = 1'b1,
    parameter bit          REPEAT_ENABLE = 1'b0
) (
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        rxIN,
    output logic        dataReceivedOUT,
    output logic [31:0] dataOUT
);

    // A clock slower than the tick rate degenerates to one tick per clock.
    localparam int unsigned c_TICK_DIV =
        (CLOCK_SPEED / TICK_HZ) > 0 ? (CLOCK_SPEED / TICK_HZ) : 1;
    localparam logic [5:0]  c_LAST_BIT = 6'(NEC_BITS - 1);

    // ------------------------------------------------------------------
    // Timing base
    // ------------------------------------------------------------------
    logic w_tick;

    ClockDivider #(
        .VALUE (c_TICK_DIV)
    ) u_tick_div (
        .clk_i  (clkIN),
        .rst_ni (nResetIN),
        .tick_o (w_tick)
    );

    logic rx_q;
    dur_t dur_q;
    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_sat;

    assign w_rise = rxIN & ~rx_q;
    assign w_fall = ~rxIN & rx_q;
    assign w_edge = w_rise | w_fall;
    assign w_sat  = (dur_q == DUR_MAX);

    // dur_q holds the length of the current level; at an edge it is the
    // length of the level that the edge terminates.
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            rx_q  <= 1'b0;
            dur_q <= '0;
        end else begin
            rx_q <= rxIN;
            if (w_edge) begin
                dur_q <= '0;
            end else if (w_tick && !w_sat) begin
                dur_q <= dur_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    nec_state_t  state_q,  state_d;
    logic [31:0] sr_q,     sr_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic        rpt_q,    rpt_d;
    logic        valid_q,  valid_d;
    logic [31:0] data_q,   data_d;
    logic        strobe_q, strobe_d;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bitcnt_q <= '0;
            rpt_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            rpt_q    <= rpt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        rpt_d    = rpt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_rise) begin
                    state_d = LEAD_MARK;
                    rpt_d   = 1'b0;
                end
            end
            LEAD_MARK: begin
                if (w_fall) begin
                    state_d = in_window(dur_q, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
                end
            end
            LEAD_SPACE: begin
                if (w_rise) begin
                    if (in_window(dur_q, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
                        state_d  = BIT_MARK;
                        bitcnt_d = '0;
                    end else if (in_window(dur_q, LEAD_REP_MIN, LEAD_REP_MAX)) begin
                        state_d = STOP_MARK;
                        rpt_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BIT_MARK: begin
                if (w_fall) begin
                    state_d = in_window(dur_q, BIT_MARK_MIN, BIT_MARK_MAX) ? BIT_SPACE : IDLE;
                end
            end
            BIT_SPACE: begin
                // The bit value is only known once its space ends.
                if (w_rise) begin
                    if (in_window(dur_q, SPACE0_MIN, SPACE0_MAX) ||
                        in_window(dur_q, SPACE1_MIN, SPACE1_MAX)) begin
                        sr_d     = {sr_q[30:0], in_window(dur_q, SPACE1_MIN, SPACE1_MAX)};
                        bitcnt_d = bitcnt_q + 1'b1;
                        state_d  = (bitcnt_q == c_LAST_BIT) ? STOP_MARK : BIT_MARK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STOP_MARK: begin
                if (w_fall) begin
                    state_d = IDLE;
                    if (in_window(dur_q, STOP_MARK_MIN, STOP_MARK_MAX)) begin
                        if (rpt_q) begin
                            strobe_d = REPEAT_ENABLE && valid_q;
                        end else if (!CHECK_INVERSE || (sr_q[7:0] == ~sr_q[15:8])) begin
                            data_d   = sr_q;
                            valid_d  = 1'b1;
                            strobe_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A line that stops toggling mid-frame abandons the frame.
        if ((state_q != IDLE) && !w_edge && w_sat) begin
            state_d = IDLE;
        end
    end

    assign dataOUT         = data_q;
    assign dataReceivedOUT = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_ir_decoder
// Description : Self-checking bench. Two decoders share one IR line: A checks
//               the inverse byte and ignores repeats, B skips the inverse
//               check and honours repeats. One tick per clock keeps frames
//               short; line durations are given in clocks, a level of N
//               clocks measures as N-1 ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_ir_decoder;

    localparam bit CHK_A = 1'b1, RPT_A = 1'b0;
    localparam bit CHK_B = 1'b0, RPT_B = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        str_a, str_b;
    logic [31:0] data_a, data_b;

    nec_ir_decoder #(
        .CLOCK_SPEED(100_000), .TICK_HZ(100_000),
        .CHECK_INVERSE(CHK_A), .REPEAT_ENABLE(RPT_A)
    ) dut_a (
        .clkIN(clk), .nResetIN(rst_n), .rxIN(rx),
        .dataReceivedOUT(str_a), .dataOUT(data_a)
    );

    nec_ir_decoder #(
        .CLOCK_SPEED(100_000), .TICK_HZ(100_000),
        .CHECK_INVERSE(CHK_B), .REPEAT_ENABLE(RPT_B)
    ) dut_b (
        .clkIN(clk), .nResetIN(rst_n), .rxIN(rx),
        .dataReceivedOUT(str_b), .dataOUT(data_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int stop_cyc = 0;
    bit jitter = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters and guarantee monitors, sampled mid-cycle.
    int n_a = 0, n_b = 0, last_cyc_a = -1, last_cyc_b = -1;
    int viol_pulse = 0, viol_data = 0;
    logic        prev_sa = 1'b0, prev_sb = 1'b0;
    logic [31:0] prev_da = '0, prev_db = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (str_a) begin n_a++; last_cyc_a = cyc; end
            if (str_b) begin n_b++; last_cyc_b = cyc; end
            if ((str_a && prev_sa) || (str_b && prev_sb)) viol_pulse++;
            if ((data_a !== prev_da && !str_a) || (data_b !== prev_db && !str_b)) viol_data++;
        end
        prev_sa = str_a; prev_sb = str_b;
        prev_da = data_a; prev_db = data_b;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Reference model: what each decoder should do with a well-timed frame
    // ---------------------------------------------------------------
    logic [31:0] exp_a = '0, exp_b = '0;
    bit          val_a = 1'b0, val_b = 1'b0;

    function automatic bit inv_ok(input logic [31:0] w);
        logic [7:0] hi;
        hi = w[15:8];
        return w[7:0] == ~hi;
    endfunction

    task automatic model_frame(input logic [31:0] w, input bit is_rep, output int ea, output int eb);
        ea = 0; eb = 0;
        if (is_rep) begin
            if (RPT_A && val_a) ea = 1;
            if (RPT_B && val_b) eb = 1;
        end else begin
            if (!CHK_A || inv_ok(w)) begin exp_a = w; val_a = 1'b1; ea = 1; end
            if (!CHK_B || inv_ok(w)) begin exp_b = w; val_b = 1'b1; eb = 1; end
        end
    endtask

    // ---------------------------------------------------------------
    // Line drivers
    // ---------------------------------------------------------------
    function automatic int dur(input int lo, input int hi, input int nom);
        return jitter ? int'($urandom_range(hi, lo)) : nom;
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends lead + nbits bits; bad_idx >= 0 replaces that bit's space by
    // bad_sp clocks and abandons the frame after one more mark.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int lead_m,
                              input int bad_idx, input int bad_sp, input bit stop);
        bit done;
        done = 1'b0;
        hold(1'b1, lead_m);
        hold(1'b0, dur(415, 485, 451));
        for (int i = 0; i < nbits && !done; i++) begin
            hold(1'b1, dur(45, 65, 57));
            if (i == bad_idx) begin
                hold(1'b0, bad_sp);
                hold(1'b1, 57);
                done = 1'b1;
            end else begin
                hold(1'b0, w[31-i] ? dur(145, 185, 170) : dur(45, 65, 57));
            end
        end
        if (stop && !done) begin
            hold(1'b1, dur(45, 65, 57));
            stop_cyc = cyc;
        end
        rx = 1'b0;
    endtask

    task automatic send_repeat();
        hold(1'b1, dur(820, 980, 901));
        hold(1'b0, dur(205, 245, 226));
        hold(1'b1, dur(45, 65, 57));
        stop_cyc = cyc;
        rx = 1'b0;
    endtask

    function automatic logic [31:0] rand_word(input bit force_valid);
        logic [31:0] w;
        w = $urandom;
        if (force_valid) w[7:0] = ~w[15:8];
        return w;
    endfunction

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (str_a !== 1'b0 || str_b !== 1'b0) begin fails++;
            $display("FAIL reset_strobe: got a=%b b=%b, expected 0", str_a, str_b); end
        checks++; if (data_a !== 32'h0 || data_b !== 32'h0) begin fails++;
            $display("FAIL reset_data: got a=%h b=%h, expected 0", data_a, data_b); end
        rst_n = 1'b1;
        hold(1'b0, 20);
    endtask

    task automatic test_nominal();
        int na0, nb0, ea, eb;
        logic [31:0] w;
        w = 32'h00ffc23d;
        na0 = n_a; nb0 = n_b;
        jitter = 1'b0;
        send_frame(w, 32, 901, -1, 0, 1'b1);
        jitter = 1'b1;
        model_frame(w, 1'b0, ea, eb);
        hold(1'b0, 40);
        checks++; if (n_a - na0 != ea || n_b - nb0 != eb) begin fails++;
            $display("FAIL nominal_strobes: got a=%0d b=%0d, expected a=%0d b=%0d", n_a-na0, n_b-nb0, ea, eb); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL nominal_data: got a=%h b=%h, expected %h", data_a, data_b, exp_a); end
        checks++; if (last_cyc_a != stop_cyc + 1 || last_cyc_b != stop_cyc + 1) begin fails++;
            $display("FAIL nominal_latency: strobe at a=%0d b=%0d, expected %0d", last_cyc_a, last_cyc_b, stop_cyc+1); end
    endtask

    task automatic test_inverse();
        int na0, nb0, ea, eb;
        logic [31:0] w;
        w = 32'h00ff9070;
        na0 = n_a; nb0 = n_b;
        send_frame(w, 32, dur(820, 980, 901), -1, 0, 1'b1);
        model_frame(w, 1'b0, ea, eb);
        hold(1'b0, 40);
        checks++; if (n_a - na0 != ea) begin fails++;
            $display("FAIL inverse_strobe_a: got %0d, expected %0d", n_a-na0, ea); end
        checks++; if (data_a !== exp_a) begin fails++;
            $display("FAIL inverse_data_a: got %h, expected %h", data_a, exp_a); end
        checks++; if (n_b - nb0 != eb) begin fails++;
            $display("FAIL inverse_strobe_b: got %0d, expected %0d", n_b-nb0, eb); end
        checks++; if (data_b !== exp_b) begin fails++;
            $display("FAIL inverse_data_b: got %h, expected %h", data_b, exp_b); end
    endtask

    task automatic test_bad_timing();
        int na0, nb0, ea, eb;
        logic [31:0] w;
        na0 = n_a; nb0 = n_b;
        send_frame(rand_word(1'b1), 8, 701, -1, 0, 1'b0);   // 7 ms lead mark
        hold(1'b0, 100);
        send_frame(rand_word(1'b1), 32, dur(820, 980, 901), 3, 101, 1'b1); // 1.0 ms space
        hold(1'b0, 100);
        checks++; if (n_a != na0 || n_b != nb0) begin fails++;
            $display("FAIL bad_timing_strobes: got a=%0d b=%0d, expected 0", n_a-na0, n_b-nb0); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL bad_timing_data: got a=%h b=%h, expected a=%h b=%h", data_a, data_b, exp_a, exp_b); end
        w = rand_word(1'b1);
        send_frame(w, 32, dur(820, 980, 901), -1, 0, 1'b1);
        model_frame(w, 1'b0, ea, eb);
        hold(1'b0, 40);
        checks++; if (n_a - na0 != ea || n_b - nb0 != eb) begin fails++;
            $display("FAIL after_bad_strobes: got a=%0d b=%0d, expected a=%0d b=%0d", n_a-na0, n_b-nb0, ea, eb); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL after_bad_data: got a=%h b=%h, expected %h", data_a, data_b, w); end
    endtask

    task automatic test_repeat();
        int na0, nb0, ea, eb, ra, rb;
        logic [31:0] w;
        w = rand_word(1'b1);
        na0 = n_a; nb0 = n_b;
        send_frame(w, 32, dur(820, 980, 901), -1, 0, 1'b1);
        model_frame(w, 1'b0, ea, eb);
        hold(1'b0, 200);
        send_repeat();
        model_frame(w, 1'b1, ra, rb);
        hold(1'b0, 40);
        checks++; if (n_a - na0 != ea + ra) begin fails++;
            $display("FAIL repeat_strobes_a: got %0d, expected %0d", n_a-na0, ea+ra); end
        checks++; if (n_b - nb0 != eb + rb) begin fails++;
            $display("FAIL repeat_strobes_b: got %0d, expected %0d", n_b-nb0, eb+rb); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL repeat_data: got a=%h b=%h, expected %h", data_a, data_b, w); end
    endtask

    task automatic test_reset_midframe();
        int na0, nb0, ea, eb, ra, rb;
        logic [31:0] w;
        send_frame(rand_word(1'b1), 16, dur(820, 980, 901), -1, 0, 1'b0);
        rst_n = 1'b0;
        exp_a = '0; exp_b = '0; val_a = 1'b0; val_b = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (data_a !== 32'h0 || data_b !== 32'h0 || str_a !== 1'b0 || str_b !== 1'b0) begin fails++;
            $display("FAIL midframe_reset_outputs: got a=%h/%b b=%h/%b, expected 0", data_a, str_a, data_b, str_b); end
        rst_n = 1'b1;
        hold(1'b0, 50);
        na0 = n_a; nb0 = n_b;
        send_repeat();                       // no code held since reset
        model_frame(32'h0, 1'b1, ra, rb);
        hold(1'b0, 100);
        w = rand_word(1'b1);
        send_frame(w, 32, dur(820, 980, 901), -1, 0, 1'b1);
        model_frame(w, 1'b0, ea, eb);
        hold(1'b0, 40);
        checks++; if (n_a - na0 != ea + ra || n_b - nb0 != eb + rb) begin fails++;
            $display("FAIL post_reset_strobes: got a=%0d b=%0d, expected a=%0d b=%0d", n_a-na0, n_b-nb0, ea+ra, eb+rb); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL post_reset_data: got a=%h b=%h, expected %h", data_a, data_b, w); end
    endtask

    task automatic test_truncated();
        int na0, nb0;
        na0 = n_a; nb0 = n_b;
        send_frame(rand_word(1'b1), 20, dur(820, 980, 901), -1, 0, 1'b0);
        hold(1'b0, 2100);                    // beyond counter saturation
        checks++; if (n_a != na0 || n_b != nb0) begin fails++;
            $display("FAIL truncated_strobes: got a=%0d b=%0d, expected 0", n_a-na0, n_b-nb0); end
        checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
            $display("FAIL truncated_data: got a=%h b=%h, expected a=%h b=%h", data_a, data_b, exp_a, exp_b); end
    endtask

    task automatic test_random();
        int na0, nb0, ea, eb;
        logic [31:0] w;
        for (int k = 0; k < 3; k++) begin
            w = rand_word(k != 1);
            na0 = n_a; nb0 = n_b;
            send_frame(w, 32, dur(820, 980, 901), -1, 0, 1'b1);
            model_frame(w, 1'b0, ea, eb);
            hold(1'b0, dur(30, 300, 100));
            checks++; if (n_a - na0 != ea || n_b - nb0 != eb) begin fails++;
                $display("FAIL random%0d_strobes: word %h got a=%0d b=%0d, expected a=%0d b=%0d", k, w, n_a-na0, n_b-nb0, ea, eb); end
            checks++; if (data_a !== exp_a || data_b !== exp_b) begin fails++;
                $display("FAIL random%0d_data: got a=%h b=%h, expected a=%h b=%h", k, data_a, data_b, exp_a, exp_b); end
        end
    endtask

    task automatic test_guarantees();
        checks++; if (viol_pulse != 0) begin fails++;
            $display("FAIL strobe_width: got %0d back-to-back strobes, expected 0", viol_pulse); end
        checks++; if (viol_data != 0) begin fails++;
            $display("FAIL data_stability: got %0d unstrobed data changes, expected 0", viol_data); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_inverse();
        test_bad_timing();
        test_repeat();
        test_reset_midframe();
        test_truncated();
        test_random();
        test_guarantees();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
